// File: rtl/rf_test_monitor_if.sv
// Snoop, configuration and verdict signals between a CPU bench and rf_test_monitor.
interface rf_test_monitor_if #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_CHECKS = 4,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic                         start;
  logic                         rf_we;
  logic [AW-1:0]                rf_wa;
  logic [DATA_W-1:0]            rf_wd;
  logic [DATA_W-1:0]            pc;
  logic [NUM_CHECKS-1:0]        exp_valid;
  logic [NUM_CHECKS*AW-1:0]     exp_addr;
  logic [NUM_CHECKS*DATA_W-1:0] exp_data;

  logic                         done;
  logic                         pass;
  logic [1:0]                   fail_code;
  logic [IW-1:0]                fail_idx;
  logic [NUM_CHECKS-1:0]        mismatch_mask;
  logic [CNT_W-1:0]             cycle_count;

  modport master (
    output start, rf_we, rf_wa, rf_wd, pc, exp_valid, exp_addr, exp_data,
    input  done, pass, fail_code, fail_idx, mismatch_mask, cycle_count
  );

  modport slave (
    input  start, rf_we, rf_wa, rf_wd, pc, exp_valid, exp_addr, exp_data,
    output done, pass, fail_code, fail_idx, mismatch_mask, cycle_count
  );
endinterface

// File: rtl/rf_test_monitor.sv
// End-of-test monitor: shadows watched register writes, detects PC halt or timeout,
// and reports a sticky PASS/FAIL verdict with per-slot mismatch detail.
module rf_test_monitor #(
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_CHECKS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned HALT_CYCLES    = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  rf_test_monitor_if.slave bus
);
  localparam int unsigned AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned IW  = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int unsigned HCW = $clog2(HALT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t                                state_q, state_d;
  logic [NUM_CHECKS-1:0]                 cfg_valid_q, cfg_valid_d;
  logic [NUM_CHECKS*AW-1:0]              cfg_addr_q, cfg_addr_d;
  logic [NUM_CHECKS*DATA_W-1:0]          cfg_data_q, cfg_data_d;
  logic [NUM_CHECKS-1:0]                 seen_q, seen_d;
  logic [NUM_CHECKS-1:0][DATA_W-1:0]     shadow_q, shadow_d;
  logic [DATA_W-1:0]                     prev_pc_q, prev_pc_d;
  logic                                  first_q, first_d;
  logic [HCW-1:0]                        halt_cnt_q, halt_cnt_d;

  logic                                  done_q, done_d;
  logic                                  pass_q, pass_d;
  logic [1:0]                            fail_code_q, fail_code_d;
  logic [IW-1:0]                         fail_idx_q, fail_idx_d;
  logic [NUM_CHECKS-1:0]                 mask_q, mask_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;

  logic [NUM_CHECKS-1:0]                 fail_vec;
  logic [IW-1:0]                         low_idx;
  logic                                  low_found;
  logic                                  halt;
  logic                                  timeout;
  logic [CNT_W-1:0]                      cnt_inc;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cfg_valid_d = cfg_valid_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    seen_d      = seen_q;
    shadow_d    = shadow_q;
    prev_pc_d   = prev_pc_q;
    first_d     = first_q;
    halt_cnt_d  = halt_cnt_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_code_d = fail_code_q;
    fail_idx_d  = fail_idx_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    fail_vec    = '0;
    low_idx     = '0;
    low_found   = 1'b0;
    halt        = 1'b0;
    timeout     = 1'b0;
    cnt_inc     = cnt_q;

    case (state_q)
      S_RUN: begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_d   = cnt_inc;

        // Shadow update; the evaluation below sees this cycle's write (bypass)
        for (int i = 0; i < int'(NUM_CHECKS); i++) begin
          if (bus.rf_we && (bus.rf_wa == cfg_addr_q[i*AW +: AW])) begin
            shadow_d[i] = bus.rf_wd;
            seen_d[i]   = 1'b1;
          end
          fail_vec[i] = cfg_valid_q[i] &&
                        (!seen_d[i] || (shadow_d[i] != cfg_data_q[i*DATA_W +: DATA_W]));
        end

        for (int i = 0; i < int'(NUM_CHECKS); i++) begin
          if (fail_vec[i] && !low_found) begin
            low_idx   = IW'(i);
            low_found = 1'b1;
          end
        end

        prev_pc_d = bus.pc;
        first_d   = 1'b0;
        if (first_q || (bus.pc != prev_pc_q)) halt_cnt_d = '0;
        else                                  halt_cnt_d = halt_cnt_q + HCW'(1);

        halt    = (halt_cnt_d == HCW'(HALT_CYCLES - 1));
        timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1));

        if (halt || timeout) begin
          done_d = 1'b1;
          mask_d = fail_vec;
          if (halt && (fail_vec == '0)) begin
            state_d     = S_PASS;
            pass_d      = 1'b1;
            fail_code_d = 2'd0;
          end else begin
            state_d     = S_FAIL;
            fail_code_d = halt ? 2'd1 : 2'd2;
            fail_idx_d  = halt ? low_idx : '0;
          end
        end
      end

      default: begin
        if (bus.start) begin
          cfg_valid_d = bus.exp_valid;
          cfg_addr_d  = bus.exp_addr;
          cfg_data_d  = bus.exp_data;
          seen_d      = '0;
          shadow_d    = '0;
          prev_pc_d   = '0;
          first_d     = 1'b1;
          halt_cnt_d  = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_code_d = 2'd0;
          fail_idx_d  = '0;
          mask_d      = '0;
          cnt_d       = '0;
          if (bus.exp_valid == '0) begin
            state_d     = S_FAIL;
            done_d      = 1'b1;
            fail_code_d = 2'd3;
          end else begin
            state_d = S_RUN;
          end
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cfg_valid_q <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      seen_q      <= '0;
      shadow_q    <= '0;
      prev_pc_q   <= '0;
      first_q     <= 1'b0;
      halt_cnt_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= 2'd0;
      fail_idx_q  <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      seen_q      <= seen_d;
      shadow_q    <= shadow_d;
      prev_pc_q   <= prev_pc_d;
      first_q     <= first_d;
      halt_cnt_q  <= halt_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_code_q <= fail_code_d;
      fail_idx_q  <= fail_idx_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.fail_code     = fail_code_q;
  assign bus.fail_idx      = fail_idx_q;
  assign bus.mismatch_mask = mask_q;
  assign bus.cycle_count   = cnt_q;
endmodule
